// File: rtl/sl28_intc.sv
// Interrupt controller: synchronised sources, per-source enable/polarity/mode, W1C pending.
// Optional software trigger at BASE+4 when SL28_INTC_SWTRIG_EN is defined.
module sl28_intc #(
  parameter logic [4:0] BASE_ADDR   = 5'h1a,
  parameter int         NUM_IRQS    = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_IRQS-1:0] irq_src,
  output logic                irq
);

  localparam logic [4:0] A_IE   = BASE_ADDR;
  localparam logic [4:0] A_IP   = BASE_ADDR + 5'd1;
  localparam logic [4:0] A_MODE = BASE_ADDR + 5'd2;
  localparam logic [4:0] A_POL  = BASE_ADDR + 5'd3;

  logic [NUM_IRQS-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_IRQS-1:0] ie_reg;
  logic [NUM_IRQS-1:0] ip_reg;
  logic [NUM_IRQS-1:0] mode_reg;
  logic [NUM_IRQS-1:0] pol_reg;
  logic [NUM_IRQS-1:0] qd_reg;
  logic [NUM_IRQS-1:0] q;
  logic [NUM_IRQS-1:0] set_cond;
  logic [NUM_IRQS-1:0] w1c;
  logic [NUM_IRQS-1:0] swtrig;
  logic [NUM_IRQS-1:0] ip_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= irq_src;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign q        = sync_reg[SYNC_STAGES-1] ^ pol_reg;
  assign set_cond = q & ~qd_reg;
  assign w1c      = (csr_we && (csr_a == A_IP)) ? csr_di[NUM_IRQS-1:0] : '0;

`ifdef SL28_INTC_SWTRIG_EN
  localparam logic [4:0] A_SW = BASE_ADDR + 5'd4;
  assign swtrig = (csr_we && (csr_a == A_SW)) ? csr_di[NUM_IRQS-1:0] : '0;
`else
  assign swtrig = '0;
`endif

  // Edge bits: a new set (or soft trigger) beats a same-cycle clear. Level bits track q.
  generate
    for (gi = 0; gi < NUM_IRQS; gi++) begin : g_ip
      assign ip_next[gi] = mode_reg[gi]
                         ? (set_cond[gi] | swtrig[gi] | (ip_reg[gi] & ~w1c[gi]))
                         : q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_reg   <= '0;
      ip_reg   <= '0;
      mode_reg <= '0;
      pol_reg  <= '0;
      qd_reg   <= '0;
      irq      <= 1'b0;
    end else begin
      qd_reg <= q;
      ip_reg <= ip_next;
      irq    <= |(ip_reg & ie_reg);
      if (csr_we && (csr_a == A_IE))   ie_reg   <= csr_di[NUM_IRQS-1:0];
      if (csr_we && (csr_a == A_MODE)) mode_reg <= csr_di[NUM_IRQS-1:0];
      if (csr_we && (csr_a == A_POL))  pol_reg  <= csr_di[NUM_IRQS-1:0];
    end
  end

  always_comb begin
    csr_do = 8'h00;
    case (csr_a)
      A_IE:    csr_do = 8'(ie_reg);
      A_IP:    csr_do = 8'(ip_reg);
      A_MODE:  csr_do = 8'(mode_reg);
      A_POL:   csr_do = 8'(pol_reg);
      default: csr_do = 8'h00;
    endcase
  end

endmodule

// File: doc/sl28_intc.md
# sl28_intc

Parametrised interrupt controller for the board-control CPLD. It aggregates up to eight asynchronous interrupt sources into one registered interrupt line, with per-source enable, polarity, level/edge mode and a write-1-to-clear pending register. It sits on the shared 5-bit CSR bus behind the I2C slave, next to the PWM and GPIO blocks. Its output replaces the plain OR of the GPIO block interrupts that drives the CPLD interrupt pin.

## Interface

Parameters:
- BASE_ADDR, 5'h1a: first CSR address of the block. BASE_ADDR+4 must be ≤ 5'h1f.
- NUM_IRQS, 8: number of sources, 1..8.
- SYNC_STAGES, 2: synchroniser flops per source, ≥ 2.

Ports:
- clk, input, 1: single clock for the whole block.
- rst_n, input, 1: asynchronous, active-low reset.
- csr_a, input, 5: CSR address.
- csr_di, input, 8: CSR write data.
- csr_we, input, 1: CSR write strobe, one cycle per write.
- csr_do, output, 8: CSR read data. Combinational from csr_a. 8'h00 when csr_a is outside this block, so it can be ORed onto the bus.
- irq_src, input, NUM_IRQS: asynchronous interrupt sources.
- irq, output, 1: registered, active-high interrupt output.

## Operation

Registers, bit n maps to source n. Bits at and above NUM_IRQS read 0 and ignore writes.
- BASE+0 IE (rw): interrupt enable.
- BASE+1 IP (r/w1c): pending bits.
- BASE+2 MODE (rw): 1 = edge, 0 = level.
- BASE+3 POL (rw): 1 = invert the source, i.e. active-low or falling edge.
- BASE+4 SWTRIG (wo, reads 0): present only with the macro described under Configuration.

Per-source pipeline:
- The source passes through SYNC_STAGES flops to give s.
- q = s ^ POL[n].
- q_d is q registered one clock later.
- Edge mode, set condition: q & ~q_d.
  - IP[n] is sticky once set.
  - A W1C of 1 clears IP[n].
  - If a set condition and a W1C fall in the same cycle, the set wins and IP stays 1.
- Level mode: IP[n] <= q every cycle, and W1C has no effect.
- Switching MODE from edge to level: IP takes q on the next clock.
- Switching MODE from level to edge: IP keeps its current value.
- Writing POL or MODE can create a set condition. Software clears IP after reconfiguring.
- irq <= |(IP & IE), registered. Writing IE changes irq one clock after the write cycle.

Reset values:
- IE, IP, MODE, POL, all synchroniser flops, q_d and irq are 0.
- csr_do is 0 for any address outside the block.
- A source already active (after POL) when rst_n releases registers as an edge, because q_d starts at 0. Since IE = 0, irq stays 0.

## Timing

- Source assert to IP set: SYNC_STAGES+1 rising edges after the first sampling edge.
- Source assert to irq: SYNC_STAGES+2 rising edges. With the default parameters that is 4 clocks.
- CSR write: takes effect at the clock edge where csr_we = 1. The register read-back shows the new value in the following cycle.
- W1C on IP: IP clears at the write edge, and irq falls one edge later, unless a new set condition wins.
- Source pulses shorter than one clk period may be missed. Pulses of at least one period are guaranteed to be captured in edge mode.
- rst_n assertion mid-operation: all state clears immediately and irq drops asynchronously.

## Configuration

- SL28_INTC_SWTRIG_EN defined:
  - BASE+4 is a write-only SWTRIG register.
  - Writing 1 to bit n sets IP[n] in the write cycle. This applies in edge mode only. In level mode the write is ignored.
  - SWTRIG has priority over nothing else because it shares no cycle with a W1C.
  - Reads of BASE+4 return 0.
- SL28_INTC_SWTRIG_EN undefined:
  - BASE+4 is not decoded; writes are ignored and reads return 0 (csr_do = 8'h00).

## Test plan

- **Reset and read-back:** hold rst_n low, apply irq_src = 8'hff, release, read BASE+0..3 -> IE = 00, MODE = 00, POL = 00, IP = ff (reset-release edges). irq stays 0 throughout.
- **Edge mode end to end:** write MODE = 01, IE = 01, W1C IP = ff, pulse irq_src[0] high for 1 clk -> IP = 01 and irq = 1 exactly 4 clocks after the sampling edge. W1C IP = 01 -> irq = 0 one clock later.
- **Level mode and polarity:** write MODE = 00, POL = 02, IE = 02, drive irq_src[1] = 0 -> irq = 1. Drive irq_src[1] = 1 -> irq = 0 after 4 clocks. W1C IP = 02 while the source is active -> IP stays 02.
- **Set/clear collision:** in edge mode, time a source rising edge so its set condition lands in the W1C cycle -> IP bit remains 1 and irq remains 1.
- **Parameter and bus checks:** with NUM_IRQS = 3, write IE = ff -> reads 07. Reading any address outside BASE..BASE+4 -> csr_do = 00.
- **SWTRIG (macro defined):** MODE = 10, IE = 10, write BASE+4 = 10 -> IP = 10 and irq = 1 one clock later. With MODE = 00, the same write leaves IP[4] following the source. With the macro undefined, writing BASE+4 has no effect on IP.
